// File: rtl/hba_rr_arbiter.sv
// Round-robin bus arbiter for four masters.
// A request wins a registered one-hot grant. The grant is held until the master
// starts a transaction (hba_select) or until GRANT_WAIT cycles pass. Ownership
// lasts while hba_select stays high. If ownership runs longer than HOLD_MAX
// cycles, a sticky error flag is raised.
//
// state | meaning
// IDLE  | no grant; arbitrate when the bus is free (hba_select low)
// GRANT | grant driven, waiting for the winner to raise hba_select
// OWNED | winner owns the bus; hold_cnt tracks ownership length
module hba_rr_arbiter #(
    parameter int GRANT_WAIT = 4,
    parameter int HOLD_MAX   = 255
) (
    input  logic       hba_clk,
    input  logic       hba_reset,
    input  logic       hba_select,
    input  logic [3:0] hba_mrequest,
    output logic [3:0] hba_mgrant,
    output logic [1:0] arb_owner,
    output logic       arb_busy,
    output logic       arb_timeout,
    output logic       arb_hold_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_OWNED = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LAST  = 4'(GRANT_WAIT - 1);
    localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);

    state_t     state_q, state_d;
    logic [3:0] mgrant_q, mgrant_d;
    logic [1:0] owner_q, owner_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic       hold_err_q, hold_err_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;

    // Round-robin pick: first asserted request at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        cand      = '0;
        for (int i = 0; i < 4; i++) begin
            cand = rr_ptr_q + 2'(i);
            if (!win_found && hba_mrequest[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        mgrant_d   = mgrant_q;
        owner_d    = owner_q;
        timeout_d  = 1'b0;
        hold_err_d = hold_err_q;
        rr_ptr_d   = rr_ptr_q;
        wait_cnt_d = wait_cnt_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                mgrant_d = '0;
                if (!hba_select && win_found) begin
                    mgrant_d   = 4'b0001 << win_idx;
                    owner_d    = win_idx;
                    wait_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (hba_select) begin
                    // A transaction start beats a simultaneous timeout.
                    mgrant_d   = '0;
                    hold_cnt_d = '0;
                    state_d    = ST_OWNED;
                end else if (!hba_mrequest[owner_q]) begin
                    // Withdrawn request: the pointer stays put, so this master keeps its turn.
                    mgrant_d = '0;
                    state_d  = ST_IDLE;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    mgrant_d  = '0;
                    timeout_d = 1'b1;
                    rr_ptr_d  = owner_q + 2'd1;
                    state_d   = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            ST_OWNED: begin
                mgrant_d = '0;
                if (hba_select) begin
                    if (hold_cnt_q != HOLD_LIMIT) begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                    if (hold_cnt_d == HOLD_LIMIT) begin
                        hold_err_d = 1'b1;
                    end
                end else begin
                    rr_ptr_d = owner_q + 2'd1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                mgrant_d = '0;
                state_d  = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_OWNED);
    end

    // State and output registers; reset clears the grant without waiting for a clock edge.
    always_ff @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            state_q    <= ST_IDLE;
            mgrant_q   <= '0;
            owner_q    <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            hold_err_q <= 1'b0;
            rr_ptr_q   <= '0;
            wait_cnt_q <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mgrant_q   <= mgrant_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            hold_err_q <= hold_err_d;
            rr_ptr_q   <= rr_ptr_d;
            wait_cnt_q <= wait_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign hba_mgrant   = mgrant_q;
    assign arb_owner    = owner_q;
    assign arb_busy     = busy_q;
    assign arb_timeout  = timeout_q;
    assign arb_hold_err = hold_err_q;

endmodule

// File: tb/tb_hba_rr_arbiter.sv
// Bench for hba_rr_arbiter: directed scenarios and a random run, all checked
// against a cycle-level reference model.
module tb_hba_rr_arbiter;

    localparam int GW = 4;
    localparam int HM = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] mgrant;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;
    logic       hold_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state. m_st: 0 = no grant, 1 = granted, 2 = owned.
    int m_st, m_owner, m_ptr, m_age, m_own, m_err, m_to;

    hba_rr_arbiter #(.GRANT_WAIT(GW), .HOLD_MAX(HM)) dut (
        .hba_clk      (clk),
        .hba_reset    (rst),
        .hba_select   (sel),
        .hba_mrequest (req),
        .hba_mgrant   (mgrant),
        .arb_owner    (owner),
        .arb_busy     (busy),
        .arb_timeout  (timeout),
        .arb_hold_err (hold_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // The grant must never have more than one bit set.
    always @(negedge clk) begin
        if (!rst) check_val("onehot", 32'($countones(mgrant) <= 1), 32'd1);
    end

    task automatic model_reset();
        m_st = 0; m_owner = 0; m_ptr = 0; m_age = 0; m_own = 0; m_err = 0; m_to = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic s);
        int w;
        bit found;
        m_to = 0;
        case (m_st)
            0: begin
                if (!s && r != 4'b0) begin
                    found = 0;
                    w = 0;
                    for (int k = 0; k < 4; k++) begin
                        if (!found && r[(m_ptr + k) % 4]) begin
                            found = 1;
                            w = (m_ptr + k) % 4;
                        end
                    end
                    m_owner = w;
                    m_age = 0;
                    m_st = 1;
                end
            end
            1: begin
                if (s) begin
                    m_st = 2;
                    m_own = 0;
                end else if (!r[m_owner]) begin
                    m_st = 0;
                end else begin
                    m_age++;
                    if (m_age >= GW) begin
                        m_to = 1;
                        m_ptr = (m_owner + 1) % 4;
                        m_st = 0;
                    end
                end
            end
            default: begin
                if (s) begin
                    m_own++;
                    if (m_own >= HM) m_err = 1;
                end else begin
                    m_ptr = (m_owner + 1) % 4;
                    m_st = 0;
                end
            end
        endcase
    endtask

    function automatic logic [3:0] m_grant();
        return (m_st == 1) ? 4'(1 << m_owner) : 4'b0;
    endfunction

    task automatic compare_all();
        check_val("mgrant", 32'(mgrant), 32'(m_grant()));
        check_val("owner", 32'(owner), 32'(m_owner));
        check_val("busy", 32'(busy), 32'(m_st == 2));
        check_val("timeout", 32'(timeout), 32'(m_to));
        check_val("hold_err", 32'(hold_err), 32'(m_err));
    endtask

    // Apply one cycle of inputs, advance the model, and compare after the edge.
    task automatic step(input logic [3:0] r, input logic s);
        req = r;
        sel = s;
        @(posedge clk);
        model_edge(r, s);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        sel = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();

        // Basic round-robin sequence.
        do_reset();
        step(4'b1010, 1'b0);
        check_val("rr_first", 32'(mgrant), 32'h2);
        step(4'b1010, 1'b1);
        check_val("busy_c1", 32'(busy), 32'd1);
        step(4'b1010, 1'b1);
        check_val("busy_c2", 32'(busy), 32'd1);
        step(4'b1010, 1'b0);
        check_val("busy_off", 32'(busy), 32'd0);
        step(4'b1010, 1'b0);
        check_val("rr_second", 32'(mgrant), 32'h8);
        step(4'b1010, 1'b1);
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b0);
        check_val("rr_third", 32'(mgrant), 32'h2);

        // Grant wait expiry with a single requester.
        do_reset();
        for (int i = 0; i < GW; i++) begin
            step(4'b0001, 1'b0);
            check_val("wait_grant", 32'(mgrant), 32'h1);
        end
        step(4'b0001, 1'b0);
        check_val("to_grant", 32'(mgrant), 32'h0);
        check_val("to_pulse", 32'(timeout), 32'd1);
        step(4'b0001, 1'b0);
        check_val("to_regrant", 32'(mgrant), 32'h1);
        check_val("to_clear", 32'(timeout), 32'd0);

        // A foreign transaction blocks arbitration.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b1);
            check_val("foreign", 32'(mgrant), 32'h0);
        end
        step(4'b1111, 1'b0);
        check_val("after_foreign", 32'(mgrant), 32'h1);

        // Hold error when ownership lasts too long.
        step(4'b0001, 1'b1);
        for (int i = 1; i <= HM; i++) begin
            step(4'b0001, 1'b1);
            if (i == HM - 1) check_val("hold_pre", 32'(hold_err), 32'd0);
            if (i == HM) check_val("hold_set", 32'(hold_err), 32'd1);
        end
        check_val("hold_busy", 32'(busy), 32'd1);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        check_val("hold_sticky", 32'(hold_err), 32'd1);
        do_reset();
        check_val("hold_cleared", 32'(hold_err), 32'd0);

        // A withdrawn request keeps the pointer in place.
        step(4'b0100, 1'b0);
        check_val("wd_grant", 32'(mgrant), 32'h4);
        step(4'b0000, 1'b0);
        check_val("wd_drop", 32'(mgrant), 32'h0);
        check_val("wd_noto", 32'(timeout), 32'd0);
        step(4'b1100, 1'b0);
        check_val("wd_again", 32'(mgrant), 32'h4);

        // Reset in the middle of a grant clears it without a clock edge.
        do_reset();
        step(4'b0010, 1'b0);
        check_val("pre_async", 32'(mgrant), 32'h2);
        rst = 1'b1;
        #1;
        check_val("async_clr", 32'(mgrant), 32'h0);
        do_reset();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hba_rr_arbiter.md
HBA_RR_ARBITER -- requirements
Module: hba_rr_arbiter

Interface
REQ-001 Parameter GRANT_WAIT, default 4: cycles a grant is held waiting for hba_select before revocation (range 1..15).
REQ-002 Parameter HOLD_MAX, default 255: bus-ownership cycles before hold-error flag (range 1..255).
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-004 hba_clk  input  1  bus clock; all state on rising edge.
REQ-005 hba_reset  input  1  asynchronous, active-high reset.
REQ-006 hba_select  input  1  high while any master drives a bus transaction.
REQ-007 hba_mrequest  input  4  per-master bus request, level, held until served.
REQ-008 hba_mgrant  output  4  one-hot grant, registered.
REQ-009 arb_owner  output  2  index of current/last granted master.
REQ-010 arb_busy  output  1  high while a granted master owns the bus (state OWNED).
REQ-011 arb_timeout  output  1  one-cycle pulse on grant revocation (GRANT_WAIT expiry).
REQ-012 arb_hold_err  output  1  sticky; set when ownership exceeds HOLD_MAX cycles.

Function
REQ-013 The FSM SHALL have states IDLE, GRANT, and OWNED; all outputs SHALL be registered.
REQ-014 Priority SHALL be round-robin: the winner is the first asserted request at or after rr_ptr, scanning upward modulo 4.
REQ-015 IDLE: if hba_select=0 and any request is set, then at the next edge assert hba_mgrant[winner], load arb_owner=winner, clear wait_cnt, and go to GRANT; otherwise stay in IDLE.
REQ-016 IDLE with hba_select=1 (foreign transaction) SHALL issue no grant.
REQ-017 Grant latency SHALL be 1 cycle: a request sampled high at edge N yields hba_mgrant high after edge N.
REQ-018 GRANT, hba_select=1: clear hba_mgrant, clear hold_cnt, and go to OWNED.
REQ-019 GRANT, hba_select=0, and hba_mrequest[owner]=0: clear hba_mgrant, go to IDLE, and leave rr_ptr unchanged.
REQ-020 GRANT, hba_select=0, and wait_cnt reached GRANT_WAIT-1: clear hba_mgrant, pulse arb_timeout for 1 cycle, set rr_ptr=owner+1 mod 4, and go to IDLE.
REQ-021 Otherwise, GRANT SHALL increment wait_cnt and hold the grant.
REQ-022 Simultaneous select and timeout in GRANT: select wins (REQ-018), with no timeout pulse.
REQ-023 OWNED: arb_busy=1; hold_cnt increments each cycle and saturates at HOLD_MAX.
REQ-024 When hold_cnt reaches HOLD_MAX with hba_select still high, arb_hold_err SHALL set to 1 and stay set until reset; ownership SHALL NOT be revoked.
REQ-025 OWNED with hba_select=0: set rr_ptr=owner+1 mod 4 and go to IDLE, which enforces at least one idle cycle between owners.
REQ-026 hba_mgrant SHALL never have more than one bit set, and SHALL be zero in every state except GRANT.
REQ-027 Request changes from non-owners SHALL have no effect outside IDLE.

Reset
REQ-028 While hba_reset=1, the following SHALL hold:
- hba_mgrant=0, arb_owner=0, arb_busy=0, arb_timeout=0, arb_hold_err=0
- rr_ptr=0, wait_cnt=0, hold_cnt=0
- state=IDLE
REQ-029 Reset asserted mid-GRANT or mid-OWNED SHALL clear the grant immediately (asynchronously).
REQ-030 The first grant after reset release SHALL follow rr_ptr=0 priority.

Verification
REQ-031 Bench SHALL cover: reset, then mrequest=4'b1010 -> mgrant=4'b0010 one cycle later; select high 2 cycles then low -> arb_busy 2 cycles; next grant=4'b1000; next grant after that=4'b0010.
REQ-032 Bench SHALL cover: mrequest=4'b0001 with select never asserted -> mgrant=4'b0001 for exactly 4 cycles, arb_timeout pulse, mgrant=0; re-grant to master 0 occurs since it is the sole requester.
REQ-033 Bench SHALL cover: hba_select held high externally with mrequest=4'b1111 -> mgrant stays 0; select low -> mgrant=4'b0001 one cycle later.
REQ-034 Bench SHALL cover: ownership with select held 256 cycles (HOLD_MAX=255) -> arb_hold_err=1 at cycle 255, remains 1 after release, and clears only on reset.
REQ-035 Bench SHALL cover: grant to master 2, then mrequest[2] dropped before select -> mgrant=0 next cycle, no arb_timeout, rr_ptr unchanged (master 2 wins again if it re-requests alongside master 3).
REQ-036 Bench SHALL cover: reset asserted mid-GRANT -> mgrant=0 without a clock edge; continuous check that mgrant is one-hot-or-zero.
